// File: rtl/ms_out_buff_pkg.sv
// ms_out_buff_pkg
// Shared types and sizing for the multiply/shift output buffer.
//   FTk_t : forward token  (v = valid, r = release, c = control flag, d = data)
//   BTk_t : backward token (t, v, c mirrored upstream; n = nack / stop firing)
//   SIZE_OUT_BUFF_MS : default number of buffer entries
//   PIPE_DEPTH_MS    : default maximum operations in flight upstream
package ms_out_buff_pkg;

    localparam int SIZE_OUT_BUFF_MS = 8;
    localparam int PIPE_DEPTH_MS    = 4;
    localparam int DATA_W           = 16;

    typedef struct packed {
        logic              v;
        logic              r;
        logic              c;
        logic [DATA_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic t;
        logic v;
        logic c;
        logic n;
    } BTk_t;

endpackage

// File: rtl/ms_buff_ram.sv
// ms_buff_ram
// Token storage for the output buffer: one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by the
// pointers and occupancy count in the parent.
//   clock    : system clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : token written at i_waddr
//   i_raddr  : read address
//   o_rdata  : token stored at i_raddr (combinational)
module ms_buff_ram
    import ms_out_buff_pkg::*;
#(
    parameter int DEPTH = SIZE_OUT_BUFF_MS
) (
    input  logic                     clock,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  FTk_t                     i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output FTk_t                     o_rdata
);

    FTk_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ms_out_buff.sv
// ms_out_buff
// In-order result buffer behind the variable-latency multiply/shift cluster.
// Results are captured as they leave the pipeline and replayed to the next
// element under the forward/backward token handshake. Space is reserved for
// every operation already fired into the pipeline, so upstream is told to
// stop firing early enough that no in-flight result ever finds the buffer full.
//   clock    : system clock
//   reset    : asynchronous, active-low reset
//   I_Active : module activation; low blocks pushes/pops and hides the head
//   I_Fired  : upstream issued one operation this cycle
//   I_FTk    : result token from upstream
//   O_FTk    : head-of-buffer token to downstream
//   I_BTk    : backward token from downstream (n = nack)
//   O_BTk    : backward token to upstream (n = stop firing)
//   O_Count  : occupied entries
//   O_Err    : sticky overflow / unmatched-result flag
module ms_out_buff
    import ms_out_buff_pkg::*;
#(
    parameter int SIZE_OUT_BUFF = SIZE_OUT_BUFF_MS,
    parameter int PIPE_DEPTH    = PIPE_DEPTH_MS
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               I_Active,
    input  logic                               I_Fired,
    input  FTk_t                               I_FTk,
    output FTk_t                               O_FTk,
    input  BTk_t                               I_BTk,
    output BTk_t                               O_BTk,
    output logic [$clog2(SIZE_OUT_BUFF+1)-1:0] O_Count,
    output logic                               O_Err
);

    localparam int PTR_W = $clog2(SIZE_OUT_BUFF);
    localparam int CNT_W = $clog2(SIZE_OUT_BUFF + 1);
    localparam int IFL_W = $clog2(PIPE_DEPTH + 1);
    // One extra bit holds Count + InFlight, which never exceeds 2*SIZE_OUT_BUFF.
    localparam int SUM_W = CNT_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [IFL_W-1:0] r_inflight;
    logic             r_err;

    logic [CNT_W-1:0] w_count_nxt;
    logic [IFL_W-1:0] w_inflight_nxt;
    logic             w_err_nxt;
    logic             w_fire;
    logic             w_push_req;
    logic             w_push_ok;
    logic             w_pop;
    logic             w_full;
    logic             w_head_v;
    logic             w_release;
    logic             w_overflow;
    logic             w_unmatched;
    logic             w_stop;
    logic [SUM_W-1:0] w_reserved;
    FTk_t             w_head;

    ms_buff_ram #(
        .DEPTH (SIZE_OUT_BUFF)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (I_FTk),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign w_fire     = I_Fired & I_Active;
    assign w_push_req = I_Active & I_FTk.v;
    assign w_full     = (r_count == CNT_W'(SIZE_OUT_BUFF));

    // The reset term keeps the head hidden for the whole reset pulse, not
    // just from the next edge on.
    assign w_head_v   = (r_count != '0) & I_Active & reset;
    assign w_pop      = w_head_v & ~I_BTk.n;

    // A pop in the same cycle frees the slot, so a push at full still fits.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_overflow = w_push_req & w_full & ~w_pop;
    assign w_release  = w_pop & w_head.r;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // InFlight tracks operations fired but not yet returned. A result that
    // arrives with nothing outstanding is a protocol error; the counter holds
    // at zero rather than wrapping.
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_unmatched    = w_push_req & (r_inflight == '0);
        if (w_release) begin
            // Releasing retires everything outstanding; a fire in the same
            // cycle belongs to the next batch and is still counted.
            w_inflight_nxt = w_fire ? IFL_W'(1) : '0;
        end else begin
            unique case ({w_fire, w_push_req})
                2'b10: begin
                    if (r_inflight != IFL_W'(PIPE_DEPTH)) begin
                        w_inflight_nxt = r_inflight + IFL_W'(1);
                    end
                end
                2'b01: begin
                    if (r_inflight != '0) begin
                        w_inflight_nxt = r_inflight - IFL_W'(1);
                    end
                end
                default: w_inflight_nxt = r_inflight;
            endcase
        end
    end

    assign w_err_nxt = r_err | w_overflow | w_unmatched;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Stop firing once stored plus reserved entries would fill the buffer.
    assign w_reserved = SUM_W'(r_count) + SUM_W'(r_inflight);
    assign w_stop     = (w_reserved >= SUM_W'(SIZE_OUT_BUFF)) | ~I_Active;

    always_comb begin
        O_FTk = '0;
        if (w_head_v) begin
            O_FTk   = w_head;
            O_FTk.v = 1'b1;
        end
    end

    always_comb begin
        O_BTk = '0;
        if (reset) begin
            O_BTk.t = I_BTk.t;
            O_BTk.v = I_BTk.v;
            O_BTk.c = I_BTk.c;
            O_BTk.n = w_stop;
        end
    end

    assign O_Count = r_count;
    assign O_Err   = r_err;

endmodule
